// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-memory slave with programmable wait states
//
// Answers InstMem_Read/InstMem_Address fetches with InstMem_In/InstMem_Ack from a
// word-addressed RAM window [BASE_ADDR, BASE_ADDR+DEPTH). Optional feature macro:
// INST_MEM_STATS_EN adds a 32-bit fetch_count output.
//
// Ports:
//   clock           rising-edge system clock
//   reset           asynchronous active-high reset
//   InstMem_Address word address from the CPU
//   InstMem_Read    fetch request, held high until ack
//   InstMem_In      instruction word, valid while InstMem_Ack is high
//   InstMem_Ack     one-cycle fetch acknowledge
//   load_en         preload write strobe
//   load_idx        preload word index
//   load_data       preload data
//   addr_err        sticky out-of-window fetch flag
//   fetch_count     issued-ack counter (INST_MEM_STATS_EN only)
module inst_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          IDX_W       = 10,
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter int          WAIT_STATES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [29:0]      InstMem_Address,
    input  logic             InstMem_Read,
    output logic [31:0]      InstMem_In,
    output logic             InstMem_Ack,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_data,
    output logic             addr_err
`ifdef INST_MEM_STATS_EN
    ,
    output logic [31:0]      fetch_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [29:0]      addr_q;
    logic [29:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // Unsigned window check; addresses below BASE_ADDR must not wrap into range.
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < DEPTH_W);
    assign idx      = offset[IDX_W-1:0];

    // Preload port: writes in any state, never cleared by reset.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // The RAM read happens on the edge that leaves RESP, so the ack and data
    // appear together in the following cycle. A same-edge preload write to the
    // same index therefore returns the old word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            addr_q      <= 30'd0;
            InstMem_Ack <= 1'b0;
            InstMem_In  <= 32'd0;
            addr_err    <= 1'b0;
        end else begin
            InstMem_Ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (InstMem_Read) begin
                        addr_q <= InstMem_Address;
                        cnt    <= WS;
                        state  <= (WS == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort takes priority over the countdown.
                    if (!InstMem_Read) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt <= 4'd1) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    InstMem_Ack <= 1'b1;
                    if (in_range) begin
                        InstMem_In <= mem[idx];
                    end else begin
                        InstMem_In <= 32'h0000_0000;
                        addr_err   <= 1'b1;
                    end
                    state <= S_GAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INST_MEM_STATS_EN
    // Counts every issued ack (RESP is entered only for non-aborted fetches).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (state == S_RESP) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    localparam bit STATS_EN = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - scoreboard bench for inst_mem_responder
module tb_inst_mem_responder;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd   [3];
    logic [29:0] ad   [3];
    logic [31:0] din  [3];
    logic        ack  [3];
    logic        err  [3];
    logic [31:0] fc   [3];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   ws [3] = '{2, 0, 2};
    exp_t q  [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_mem_responder #(.DEPTH(1024), .IDX_W(10), .BASE_ADDR(30'h0), .WAIT_STATES(2)) dut0 (
        .clock(clk), .reset(reset), .InstMem_Address(ad[0]), .InstMem_Read(rd[0]),
        .InstMem_In(din[0]), .InstMem_Ack(ack[0]), .load_en(ld_en), .load_idx(ld_idx),
        .load_data(ld_data), .addr_err(err[0])
`ifdef INST_MEM_STATS_EN
        , .fetch_count(fc[0])
`endif
    );

    inst_mem_responder #(.DEPTH(1024), .IDX_W(10), .BASE_ADDR(30'h0), .WAIT_STATES(0)) dut1 (
        .clock(clk), .reset(reset), .InstMem_Address(ad[1]), .InstMem_Read(rd[1]),
        .InstMem_In(din[1]), .InstMem_Ack(ack[1]), .load_en(ld_en), .load_idx(ld_idx),
        .load_data(ld_data), .addr_err(err[1])
`ifdef INST_MEM_STATS_EN
        , .fetch_count(fc[1])
`endif
    );

    inst_mem_responder #(.DEPTH(16), .IDX_W(4), .BASE_ADDR(30'hff8), .WAIT_STATES(2)) dut2 (
        .clock(clk), .reset(reset), .InstMem_Address(ad[2]), .InstMem_Read(rd[2]),
        .InstMem_In(din[2]), .InstMem_Ack(ack[2]), .load_en(ld_en), .load_idx(ld_idx[3:0]),
        .load_data(ld_data), .addr_err(err[2])
`ifdef INST_MEM_STATS_EN
        , .fetch_count(fc[2])
`endif
    );

    // Monitor: every ack pops one expectation (data and arrival cycle).
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d]) begin
                total++;
                if (q[d].size() == 0) begin
                    bad++;
                    $display("FAIL ack_unexpected dut%0d actual data=%h cyc=%0d required no ack", d, din[d], cyc);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    if (din[d] !== e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL ack_data dut%0d actual data=%h cyc=%0d required data=%h cyc=%0d",
                                 d, din[d], cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_ack(input int d);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack[d]) return;
        end
        total++;
        bad++;
        $display("FAIL ack_timeout dut%0d actual=no ack required=ack within 40 cycles", d);
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(posedge clk);
        #1;
        ld_en   = 1'b1;
        ld_idx  = 10'(idx);
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Read held high for n fetches; address stepped after each ack.
    task automatic fetch_seq(input int d, input int n,
                             input logic [29:0] a0, input logic [29:0] a1, input logic [29:0] a2,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        logic [29:0] a [3];
        logic [31:0] e [3];
        int          base;
        a = '{a0, a1, a2};
        e = '{e0, e1, e2};
        @(posedge clk);
        #1;
        rd[d] = 1'b1;
        ad[d] = a[0];
        base  = cyc + 2 + ws[d];
        for (int i = 0; i < n; i++) begin
            exp_t x;
            x.data = e[i];
            x.cyc  = base + i * (ws[d] + 3);
            q[d].push_back(x);
        end
        for (int i = 0; i < n; i++) begin
            wait_ack(d);
            if (i + 1 < n) ad[d] = a[i + 1];
        end
        rd[d] = 1'b0;
    endtask

    initial begin
        int   c;
        exp_t x;
        reset = 1'b1;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0;
            ad[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'd0);
            check($sformatf("reset_in%0d", d), din[d], 32'd0);
            check($sformatf("reset_err%0d", d), 32'(err[d]), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        preload(0, 32'h20130003);
        preload(1, 32'h20110001);
        preload(2, 32'h02918822);

        // Latency and stepped addresses, 2 wait states.
        fetch_seq(0, 3, 30'd0, 30'd1, 30'd2, 32'h20130003, 32'h20110001, 32'h02918822);

        // Zero wait states, Read held at one address.
        fetch_seq(1, 3, 30'd1, 30'd1, 30'd1, 32'h20110001, 32'h20110001, 32'h20110001);

        // Abort in WAIT: no ack, then a normal fetch.
        @(posedge clk);
        #1 rd[0] = 1'b1; ad[0] = 30'd0;
        @(posedge clk);
        #1 rd[0] = 1'b0;
        repeat (8) @(posedge clk);
        fetch_seq(0, 1, 30'd2, 30'd0, 30'd0, 32'h02918822, 32'h0, 32'h0);

        // Out of window, then sticky error across a valid fetch.
        fetch_seq(2, 1, 30'h1010, 30'd0, 30'd0, 32'h0, 32'h0, 32'h0);
        check("oor_err_set", 32'(err[2]), 32'd1);
        fetch_seq(2, 1, 30'hff9, 30'd0, 30'd0, 32'h20110001, 32'h0, 32'h0);
        check("oor_err_sticky", 32'(err[2]), 32'd1);

        // Async reset while dut0 is waiting.
        @(posedge clk);
        #1 rd[0] = 1'b1; ad[0] = 30'd1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_ack", 32'(ack[0]), 32'd0);
        check("rst_mid_in", din[0], 32'd0);
        check("rst_mid_err", 32'(err[2]), 32'd0);
        rd[0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);

        // Preload collides with the RESP-cycle read of the same index.
        @(posedge clk);
        #1 rd[0] = 1'b1; ad[0] = 30'd0;
        c = cyc;
        x.data = 32'h20130003;
        x.cyc  = c + 4;
        q[0].push_back(x);
        repeat (3) @(posedge clk);
        #1 ld_en = 1'b1; ld_idx = 10'd0; ld_data = 32'hDEADBEEF;
        wait_ack(0);
        ld_en = 1'b0;
        rd[0] = 1'b0;
        fetch_seq(0, 1, 30'd0, 30'd0, 30'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        check("in_hold", din[0], 32'hDEADBEEF);
`ifdef INST_MEM_STATS_EN
        check("fetch_count", fc[0], 32'd2);
`endif

        repeat (4) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("queue_empty%0d", d), 32'(q[d].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Instruction-memory slave answering the Processor's InstMem_Read/InstMem_Address requests with InstMem_In/InstMem_Ack.
- Word-addressed synchronous RAM window with a programmable wait-state count.
- Bench-side preload port for filling the memory before or during a run.
- Replaces hand-timed ack generation in CPU benches; also usable as a simple on-chip boot memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the memory window
IDX_W, 10, width of word index (log2 DEPTH)
BASE_ADDR, 30'h0, word address mapped to index 0
WAIT_STATES, 2, extra cycles between request capture and ack (0..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
InstMem_Address  in  30  word address from CPU
InstMem_Read  in  1  fetch request, held high until ack
InstMem_In  out  32  instruction word returned to CPU
InstMem_Ack  out  1  one-cycle pulse; InstMem_In valid in the same cycle
load_en  in  1  preload write strobe
load_idx  in  IDX_W  preload word index
load_data  in  32  preload data
addr_err  out  1  sticky: a fetch hit an address outside the window

Behaviour:
- Reset (async assert, sync release):
  - InstMem_Ack=0, InstMem_In=0, addr_err=0, state=IDLE, wait counter=0.
  - Memory contents are not cleared.
- States and transitions:
  - IDLE: if InstMem_Read=1, latch InstMem_Address and go to WAIT with cnt=WAIT_STATES (or straight to RESP if WAIT_STATES=0).
  - WAIT: cnt decrements each cycle; when cnt reaches 0, go to RESP.
  - RESP: drive InstMem_Ack=1 for exactly 1 cycle. InstMem_In = mem[latched_addr-BASE_ADDR], read in this cycle. Then go to GAP.
  - GAP: Ack=0 for 1 cycle, no capture, then IDLE. This gives a minimum 1 idle cycle between acks.
- Latency: Read sampled high at edge N -> Ack high during cycle N+1+WAIT_STATES.
- Back-to-back fetches:
  - Read held continuously high -> fetches repeat every WAIT_STATES+3 cycles.
  - Each fetch re-captures InstMem_Address in IDLE.
- Abort: InstMem_Read low while in WAIT -> return to IDLE, no ack.
  - In RESP, the ack is still issued regardless of Read.
- Address window:
  - In range: BASE_ADDR <= addr < BASE_ADDR+DEPTH (30-bit unsigned compare, no wrap).
  - Out of range: InstMem_In=32'h0000_0000 (MIPS nop), ack is still given, addr_err set until reset.
- InstMem_In holds its last value between acks. The CPU only consumes it on Ack.
- Preload:
  - load_en=1 writes mem[load_idx]=load_data on the rising edge, in any state.
  - A load and a RESP read to the same index in the same cycle returns the OLD data (read-before-write).
- Reset mid-fetch: pending request is dropped, Ack is never issued for it.

Optional Feature:
- INST_MEM_STATS_EN defined:
  - Adds output fetch_count (32 bits), reset to 0.
  - Increments once per issued ack, including out-of-range fetches.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Does not count aborted requests.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Latency: preload idx 0..2 with 32'h20130003, 32'h20110001, 32'h02918822; WAIT_STATES=2, BASE_ADDR=0; Read=1 with Address=0 sampled at edge N -> Ack=1 only in cycle N+3, InstMem_In=32'h20130003; with Address stepped 0,1,2 the acks are 5 cycles apart and return the three words in order.
- Zero wait: WAIT_STATES=0, Read held high at Address=1 -> Ack every 3 cycles, InstMem_In=32'h20110001 each time.
- Abort: Read=1 for 1 cycle then 0 during WAIT -> no Ack; a following Read at Address=2 returns 32'h02918822 with normal latency.
- Out of range: BASE_ADDR=30'hff8, DEPTH=16, fetch Address 30'h1010 -> Ack with InstMem_In=0; addr_err=1 and stays 1 through later valid fetches until reset.
- Reset mid-fetch: assert reset asynchronously in WAIT -> Ack=0 and addr_err=0 immediately; no ack after release until a new Read.
- Preload collision: load_en to idx 0 with 32'hDEADBEEF in the RESP cycle of a fetch to idx 0 -> that ack returns the old word; the next fetch returns 32'hDEADBEEF. With INST_MEM_STATS_EN, fetch_count=2 after both acks.
